// File: rtl/alert_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alert_rx_pkg
//  Description : Shared types for the differential alert receiver array:
//                channel handshake FSM state encoding, differential pair
//                type, the two legal pair encodings and classification
//                helpers used by every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
package alert_rx_pkg;

    // Handshake state of one receiver channel.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAckHi = 2'd1,
        StAckLo = 2'd2
    } alert_state_e;

    // One differential wire pair.
    typedef struct packed {
        logic p;
        logic n;
    } diff_pair_t;

    localparam diff_pair_t c_PAIR_IDLE   = '{p: 1'b0, n: 1'b1};
    localparam diff_pair_t c_PAIR_ASSERT = '{p: 1'b1, n: 1'b0};

    function automatic logic pair_is_assert(input diff_pair_t pair);
        return (pair == c_PAIR_ASSERT);
    endfunction

    function automatic logic pair_is_idle(input diff_pair_t pair);
        return (pair == c_PAIR_IDLE);
    endfunction

    // Both wires at the same level cannot be produced by a healthy sender.
    function automatic logic pair_is_broken(input diff_pair_t pair);
        return (pair.p == pair.n);
    endfunction

endpackage : alert_rx_pkg
`default_nettype wire

// File: rtl/alert_rx_chan.sv
`default_nettype none
// ============================================================================
//  Module      : alert_rx_chan
//  Description : One differential alert receiver channel. Performs the
//                alert/ack four-phase handshake, issues level-toggle pings
//                and times out unanswered pings. All outputs registered.
//  Ports       : clk_i, rst_ni (sync, active-low)
//                alert_p_i/alert_n_i  - differential alert from sender
//                ack_p_o/ack_n_o      - differential ack to sender
//                ping_p_o/ping_n_o    - differential ping (toggle encoded)
//                ping_req_i           - one-cycle ping request
//                ping_timeout_i       - ping response window in cycles
//                alert_o, ping_ok_o, ping_fail_o, integ_fail_o - pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module alert_rx_chan
    import alert_rx_pkg::*;
#(
    parameter int unsigned TimeoutW = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alert_p_i,
    input  logic                alert_n_i,
    output logic                ack_p_o,
    output logic                ack_n_o,
    output logic                ping_p_o,
    output logic                ping_n_o,
    input  logic                ping_req_i,
    input  logic [TimeoutW-1:0] ping_timeout_i,
    output logic                alert_o,
    output logic                ping_ok_o,
    output logic                ping_fail_o,
    output logic                integ_fail_o
);

    alert_state_e        r_state;
    diff_pair_t          r_ack;
    diff_pair_t          r_ping;
    logic                r_pend;
    logic [TimeoutW-1:0] r_cnt;
    logic                r_alert;
    logic                r_ping_ok;
    logic                r_ping_fail;
    logic                r_integ_fail;

    diff_pair_t          w_alert;
    logic                w_start;
    logic                w_resp;
    logic                w_expire;
    logic [TimeoutW-1:0] w_cnt_inc;

    assign w_alert = '{p: alert_p_i, n: alert_n_i};

    // A handshake only starts from Idle; a start while a ping is pending is
    // the sender's ping response rather than a real alert.
    assign w_start = (r_state == StIdle) && pair_is_assert(w_alert);
    assign w_resp  = w_start && r_pend;

    // r_cnt holds the pending cycles already elapsed; the comparison uses
    // the count including the current cycle, so a window of N expires on the
    // N-th edge after the request and a window of 0 on the first one.
    assign w_cnt_inc = (r_cnt == {TimeoutW{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_expire  = r_pend && !w_resp && (w_cnt_inc >= ping_timeout_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_ack        <= c_PAIR_IDLE;
            r_ping       <= c_PAIR_IDLE;
            r_pend       <= 1'b0;
            r_cnt        <= '0;
            r_alert      <= 1'b0;
            r_ping_ok    <= 1'b0;
            r_ping_fail  <= 1'b0;
            r_integ_fail <= 1'b0;
        end else begin
            r_alert      <= w_start && !r_pend;
            r_ping_ok    <= w_resp;
            r_ping_fail  <= w_expire;
            r_integ_fail <= pair_is_broken(w_alert);

            // A broken pair is neither assert nor idle, so Idle and AckHi
            // hold naturally while the integrity error persists.
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state <= StAckHi;
                        r_ack   <= c_PAIR_ASSERT;
                    end
                end
                StAckHi: begin
                    if (pair_is_idle(w_alert)) begin
                        r_state <= StAckLo;
                        r_ack   <= c_PAIR_IDLE;
                    end
                end
                StAckLo: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_ack   <= c_PAIR_IDLE;
                end
            endcase

            // Requests are only honoured with nothing pending, which also
            // drops a request coinciding with a response or expiry.
            if (w_resp || w_expire) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= w_cnt_inc;
            end else if (ping_req_i) begin
                r_pend   <= 1'b1;
                r_cnt    <= '0;
                r_ping.p <= ~r_ping.p;
                r_ping.n <= ~r_ping.n;
            end
        end
    end

    assign ack_p_o      = r_ack.p;
    assign ack_n_o      = r_ack.n;
    assign ping_p_o     = r_ping.p;
    assign ping_n_o     = r_ping.n;
    assign alert_o      = r_alert;
    assign ping_ok_o    = r_ping_ok;
    assign ping_fail_o  = r_ping_fail;
    assign integ_fail_o = r_integ_fail;

endmodule : alert_rx_chan
`default_nettype wire

// File: rtl/alert_rx_array.sv
`default_nettype none
// ============================================================================
//  Module      : alert_rx_array
//  Description : Array of NumAlerts independent differential alert
//                receivers sharing one ping timeout setting.
//  Ports       : clk_i, rst_ni (sync, active-low)
//                alert_p_i/alert_n_i, ack_p_o/ack_n_o, ping_p_o/ping_n_o,
//                ping_req_i, alert_o, ping_ok_o, ping_fail_o, integ_fail_o
//                - one bit per channel
//                ping_timeout_i - ping response window shared by all channels
//  Revision    : 1.0 - initial release
// ============================================================================
module alert_rx_array
    import alert_rx_pkg::*;
#(
    parameter int unsigned NumAlerts = 4,
    parameter int unsigned TimeoutW  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumAlerts-1:0] alert_p_i,
    input  logic [NumAlerts-1:0] alert_n_i,
    output logic [NumAlerts-1:0] ack_p_o,
    output logic [NumAlerts-1:0] ack_n_o,
    output logic [NumAlerts-1:0] ping_p_o,
    output logic [NumAlerts-1:0] ping_n_o,
    input  logic [NumAlerts-1:0] ping_req_i,
    input  logic [TimeoutW-1:0]  ping_timeout_i,
    output logic [NumAlerts-1:0] alert_o,
    output logic [NumAlerts-1:0] ping_ok_o,
    output logic [NumAlerts-1:0] ping_fail_o,
    output logic [NumAlerts-1:0] integ_fail_o
);

    for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
        alert_rx_chan #(
            .TimeoutW (TimeoutW)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .alert_p_i      (alert_p_i[i]),
            .alert_n_i      (alert_n_i[i]),
            .ack_p_o        (ack_p_o[i]),
            .ack_n_o        (ack_n_o[i]),
            .ping_p_o       (ping_p_o[i]),
            .ping_n_o       (ping_n_o[i]),
            .ping_req_i     (ping_req_i[i]),
            .ping_timeout_i (ping_timeout_i),
            .alert_o        (alert_o[i]),
            .ping_ok_o      (ping_ok_o[i]),
            .ping_fail_o    (ping_fail_o[i]),
            .integ_fail_o   (integ_fail_o[i])
        );
    end : g_chan

endmodule : alert_rx_array
`default_nettype wire
